// File: rtl/add64_io_stage.sv
// add64_io_stage: registered operand stage, 64-bit carry-select adder, accumulator and 2-entry result FIFO.
// Optional macro ADD64_FLAGS_EN adds signed-overflow and zero flags to each FIFO entry.
module add64_io_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic        in_cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_sum,
    output logic        out_cout,
    output logic        out_ovf,
    output logic        out_zero,
    output logic [63:0] acc_q
);
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ACC = 2'b10, OP_CLR = 2'b11} op_t;
    op_t         s1_op;
    logic        s1_valid, s1_cin;
    logic [63:0] s1_a, s1_b;
    logic [63:0] add_a, add_b, raw_sum, res_sum;
    logic        add_c, res_cout;
    logic [4:0]  carry;
    logic [1:0]  count;
    logic        wr_ptr, rd_ptr, push, pop, take;
    logic [63:0] sum_mem [2];
    logic        cout_mem [2];
    always_comb begin
        add_a    = (s1_op == OP_ACC) ? acc_q : s1_a;
        add_b    = (s1_op == OP_ACC) ? s1_a : (s1_op == OP_SUB) ? ~s1_b : s1_b;
        add_c    = (s1_op == OP_ADD) ? s1_cin : (s1_op == OP_SUB);
        res_sum  = (s1_op == OP_CLR) ? '0 : raw_sum;
        res_cout = (s1_op != OP_CLR) && carry[4];
    end
    // Each 16-bit block precomputes both carry-in cases; the incoming carry only selects.
    assign carry[0] = add_c;
    for (genvar g = 0; g < 4; g++) begin : blk
        logic [16:0] sum_0, sum_1;
        assign sum_0 = {1'b0, add_a[16*g +: 16]} + {1'b0, add_b[16*g +: 16]};
        assign sum_1 = {1'b0, add_a[16*g +: 16]} + {1'b0, add_b[16*g +: 16]} + 17'd1;
        assign raw_sum[16*g +: 16] = carry[g] ? sum_1[15:0] : sum_0[15:0];
        assign carry[g+1] = carry[g] ? sum_1[16] : sum_0[16];
    end
    assign out_valid = count != 2'd0;
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid;
    // A slot is always reserved for S1, so S1 never has to stall.
    assign in_ready  = (count - {1'b0, pop} + {1'b0, s1_valid}) < 2'd2;
    assign take      = in_valid && in_ready;
    assign out_sum   = sum_mem[rd_ptr];
    assign out_cout  = cout_mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_op       <= OP_ADD;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_cin      <= 1'b0;
            acc_q       <= '0;
            count       <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            sum_mem[0]  <= '0;
            sum_mem[1]  <= '0;
            cout_mem[0] <= 1'b0;
            cout_mem[1] <= 1'b0;
        end else begin
            s1_valid <= take;
            if (take) begin
                s1_op  <= op_t'(in_op);
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_cin <= in_cin;
            end
            if (push) begin
                sum_mem[wr_ptr]  <= res_sum;
                cout_mem[wr_ptr] <= res_cout;
                wr_ptr           <= ~wr_ptr;
                if (s1_op == OP_ACC || s1_op == OP_CLR) acc_q <= res_sum;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
`ifdef ADD64_FLAGS_EN
    logic res_ovf;
    logic ovf_mem [2];
    logic zero_mem [2];
    assign res_ovf  = (s1_op != OP_CLR) && (add_a[63] == add_b[63]) && (raw_sum[63] != add_a[63]);
    assign out_ovf  = ovf_mem[rd_ptr];
    assign out_zero = zero_mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_mem[0]  <= 1'b0;
            ovf_mem[1]  <= 1'b0;
            zero_mem[0] <= 1'b0;
            zero_mem[1] <= 1'b0;
        end else if (push) begin
            ovf_mem[wr_ptr]  <= res_ovf;
            zero_mem[wr_ptr] <= res_sum == '0;
        end
    end
`else
    assign out_ovf  = 1'b0;
    assign out_zero = 1'b0;
`endif
endmodule
